rans_byte_reverser: RTL and testbench

- Sits directly downstream of the rANS encoder.
- The encoder emits renormalisation bytes in reverse stream order: last-encoded first, with the two final-state bytes at the end.
- This block stores one frame's bytes in a LIFO RAM. When the encoder signals frame end, it replays them newest-first as an AXI-Stream byte stream with backpressure, so the decoder reads bytes in forward order.
- Also reports the frame byte count.

---
 rtl/rans_pkg.sv | 17 +
 rtl/rans_lifo_ram.sv | 27 ++
 rtl/rans_byte_reverser.sv | 157 +++++++++++++++
 tb/tb_rans_byte_reverser.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rans_pkg.sv
// rans_pkg - shared constants and state encoding for the rANS byte reverser.
// Rev 1.0
`default_nettype none

package rans_pkg;

  localparam int RANS_LIFO_ADDRWIDTH = 17;
  localparam int RANS_LEN_WIDTH      = 18;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } rans_state_t;

endpackage

`default_nettype wire

// File: rtl/rans_lifo_ram.sv
// rans_lifo_ram - simple dual-port byte RAM with a registered read port.
// Rev 1.0
`default_nettype none

module rans_lifo_ram #(
  parameter int ADDRWIDTH = 17,
  parameter int DATAWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDRWIDTH-1:0] wr_addr,
  input  logic [DATAWIDTH-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDRWIDTH-1:0] rd_addr,
  output logic [DATAWIDTH-1:0] rd_data
);

  logic [DATAWIDTH-1:0] mem [0:(1<<ADDRWIDTH)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

`default_nettype wire

// File: rtl/rans_byte_reverser.sv
// rans_byte_reverser - buffers one rANS frame in a LIFO and replays it newest-first on AXI-Stream.
// Rev 1.0
`default_nettype none

module rans_byte_reverser
  import rans_pkg::*;
#(
  parameter int ADDRWIDTH     = RANS_LIFO_ADDRWIDTH,
  parameter int DATAWIDTH_LEN = RANS_LEN_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               byte_enc,
  input  logic                     out_valid,
  input  logic                     finish,
  output logic [7:0]               m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic [DATAWIDTH_LEN-1:0] frame_len,
  output logic                     frame_len_valid,
  output logic                     busy,
  output logic                     err_ovf,
  output logic                     err_drop
);

  rans_state_t state, state_nxt;

  logic [ADDRWIDTH:0]   wr_ptr;
  logic [ADDRWIDTH-1:0] rd_ptr;
  logic                 rd_left;
  logic                 rd_pend;
  logic                 pend_last;
  logic                 byp_hit;
  logic [7:0]           byp_data;
  logic [7:0]           ram_q;
  logic [1:0]           skid_cnt;
  logic [8:0]           skid0, skid1;

  logic                 full, wr_en, fin, fin_go, pop, last_pop, rd_en, rd_last_now;
  logic [ADDRWIDTH:0]   len;
  logic [ADDRWIDTH-1:0] len_lo, rd_addr;
  logic [1:0]           occ;
  logic [8:0]           push_word;

  assign full      = wr_ptr[ADDRWIDTH];
  assign wr_en     = (state == FILL) && out_valid && !full;
  assign len       = wr_ptr + {{ADDRWIDTH{1'b0}}, wr_en};
  assign len_lo    = wr_ptr[ADDRWIDTH-1:0] - {{(ADDRWIDTH-1){1'b0}}, !wr_en};
  assign fin       = (state == FILL) && finish;
  assign fin_go    = fin && (len != '0);

  assign m_tvalid  = (skid_cnt != 2'd0);
  assign m_tdata   = skid0[7:0];
  assign m_tlast   = skid0[8] && m_tvalid;
  assign pop       = m_tvalid && m_tready;
  assign last_pop  = pop && m_tlast;
  assign busy      = (state == DRAIN);

  // A read may be issued only if the skid can absorb it after this cycle's pop.
  assign occ         = skid_cnt + {1'b0, rd_pend};
  assign rd_en       = fin_go || ((state == DRAIN) && rd_left && ((occ - {1'b0, pop}) < 2'd2));
  assign rd_addr     = fin_go ? len_lo : rd_ptr;
  assign rd_last_now = (rd_addr == '0);

  // The final byte written alongside finish is read in the same cycle, so forward it.
  assign push_word = {pend_last, (byp_hit ? byp_data : ram_q)};

  rans_lifo_ram #(
    .ADDRWIDTH (ADDRWIDTH),
    .DATAWIDTH (8)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[ADDRWIDTH-1:0]),
    .wr_data (byte_enc),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:  if (fin_go)   state_nxt = DRAIN;
      DRAIN: if (last_pop) state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr          <= '0;
      frame_len       <= '0;
      frame_len_valid <= 1'b0;
      err_ovf         <= 1'b0;
      err_drop        <= 1'b0;
      rd_ptr          <= '0;
      rd_left         <= 1'b0;
      rd_pend         <= 1'b0;
      pend_last       <= 1'b0;
      byp_hit         <= 1'b0;
      byp_data        <= 8'h00;
    end else begin
      if ((state == DRAIN) && last_pop) wr_ptr <= '0;
      else if (wr_en)                   wr_ptr <= wr_ptr + 1'b1;

      frame_len_valid <= fin;
      if (fin) frame_len <= DATAWIDTH_LEN'(len);

      if ((state == FILL) && out_valid && full)       err_ovf  <= 1'b1;
      if ((state == DRAIN) && (out_valid || finish))  err_drop <= 1'b1;

      rd_pend   <= rd_en;
      pend_last <= rd_last_now;
      byp_hit   <= fin_go && wr_en;
      byp_data  <= byte_enc;
      if (rd_en) begin
        rd_left <= !rd_last_now;
        if (!rd_last_now) rd_ptr <= rd_addr - {{(ADDRWIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_cnt <= 2'd0;
      skid0    <= 9'd0;
      skid1    <= 9'd0;
    end else if (rd_pend && !pop) begin
      if (skid_cnt == 2'd0) begin
        skid0    <= push_word;
        skid_cnt <= 2'd1;
      end else begin
        skid1    <= push_word;
        skid_cnt <= 2'd2;
      end
    end else if (!rd_pend && pop) begin
      skid0    <= skid1;
      skid_cnt <= skid_cnt - 2'd1;
    end else if (rd_pend && pop) begin
      if (skid_cnt == 2'd1) begin
        skid0 <= push_word;
      end else begin
        skid0 <= skid1;
        skid1 <= push_word;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rans_byte_reverser.sv
// tb_rans_byte_reverser - directed self-checking bench for rans_byte_reverser.
// Rev 1.0
`default_nettype none

module tb_rans_byte_reverser;

  localparam int AW = 10;
  localparam int LW = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    byte_enc = 8'h00;
  logic          out_valid = 1'b0;
  logic          finish = 1'b0;
  logic [7:0]    m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic [LW-1:0] frame_len;
  logic          frame_len_valid;
  logic          busy;
  logic          err_ovf;
  logic          err_drop;

  int n_chk = 0;
  int n_fail = 0;

  logic [8:0] q[$];
  int         tl_cnt = 0;
  int         stab_err = 0;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_out = 9'd0;

  rans_byte_reverser #(
    .ADDRWIDTH     (AW),
    .DATAWIDTH_LEN (LW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .byte_enc        (byte_enc),
    .out_valid       (out_valid),
    .finish          (finish),
    .m_tdata         (m_tdata),
    .m_tvalid        (m_tvalid),
    .m_tready        (m_tready),
    .m_tlast         (m_tlast),
    .frame_len       (frame_len),
    .frame_len_valid (frame_len_valid),
    .busy            (busy),
    .err_ovf         (err_ovf),
    .err_drop        (err_drop)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_tvalid || ({m_tlast, m_tdata} != prev_out))) stab_err++;
      if (m_tvalid && m_tready) begin
        q.push_back({m_tlast, m_tdata});
        if (m_tlast) tl_cnt++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_out   = {m_tlast, m_tdata};
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input logic fin);
    byte_enc  = b;
    out_valid = 1'b1;
    finish    = fin;
    cyc();
    out_valid = 1'b0;
    finish    = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input bit rnd);
    int start;
    bit done;
    start = tl_cnt;
    done  = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
      if (tl_cnt > start) done = 1'b1;
    end
    m_tready = 1'b1;
    chk("drain_complete", 32'(done), 32'd1);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       ov;
    logic       fin;
    logic       rdy;
    logic       tv;
    logic [7:0] d;
    logic       tl;
    logic       flv;
    int         flen;
    logic       bsy;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int errs;
    int nlast;
    logic [8:0] expw;

    // b, ov, fin, rdy | tvalid, tdata, tlast, flv, flen, busy (outputs after the edge)
    tbl[0] = '{8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0};
    tbl[1] = '{8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0};
    tbl[2] = '{8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3, 1'b1};
    tbl[3] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 0, 1'b1};
    tbl[4] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 0, 1'b1};
    tbl[5] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 0, 1'b1};
    tbl[6] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0};
    tbl[7] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0};
    tbl[8] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0};
    tbl[9] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0};

    // Reset state
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flv", 32'(frame_len_valid), 32'd0);
    chk("rst_flen", 32'(frame_len), 32'd0);
    chk("rst_errs", {30'd0, err_ovf, err_drop}, 32'd0);

    // Three-byte frame followed by an empty frame
    for (int i = 0; i < 10; i++) begin
      byte_enc  = tbl[i].b;
      out_valid = tbl[i].ov;
      finish    = tbl[i].fin;
      m_tready  = tbl[i].rdy;
      cyc();
      chk($sformatf("v%0d_tvalid", i), 32'(m_tvalid), 32'(tbl[i].tv));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("v%0d_flv", i), 32'(frame_len_valid), 32'(tbl[i].flv));
      if (tbl[i].flv) chk($sformatf("v%0d_flen", i), 32'(frame_len), 32'(tbl[i].flen));
      if (tbl[i].tv) begin
        chk($sformatf("v%0d_tdata", i), 32'(m_tdata), 32'(tbl[i].d));
        chk($sformatf("v%0d_tlast", i), 32'(m_tlast), 32'(tbl[i].tl));
      end
    end
    out_valid = 1'b0;
    finish    = 1'b0;

    // 1000 incrementing bytes drained under random backpressure
    q.delete();
    tl_cnt = 0;
    for (int i = 0; i < 1000; i++) push(8'(i), (i == 999));
    chk("t2_flv", 32'(frame_len_valid), 32'd1);
    chk("t2_flen", 32'(frame_len), 32'd1000);
    wait_drain(5000, 1'b1);
    chk("t2_count", 32'(q.size()), 32'd1000);
    errs = 0;
    nlast = 0;
    for (int k = 0; k < q.size(); k++) begin
      expw = {(k == 999), 8'(999 - k)};
      if (q[k] !== expw) errs++;
      if (q[k][8]) nlast++;
    end
    chk("t2_reverse_order", 32'(errs), 32'd0);
    chk("t2_tlast_count", 32'(nlast), 32'd1);
    cyc();
    chk("t2_busy_after", 32'(busy), 32'd0);
    chk("t2_no_errs", {30'd0, err_ovf, err_drop}, 32'd0);

    // Input arriving during DRAIN is dropped and flagged
    q.delete();
    m_tready = 1'b0;
    push(8'h10, 1'b0);
    push(8'h11, 1'b0);
    push(8'h12, 1'b0);
    push(8'h13, 1'b1);
    cyc();
    cyc();
    byte_enc  = 8'hAA;
    out_valid = 1'b1;
    finish    = 1'b1;
    cyc();
    out_valid = 1'b0;
    finish    = 1'b0;
    chk("t5_err_drop", 32'(err_drop), 32'd1);
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_stalled_head", {23'd0, m_tvalid, m_tdata}, {23'd0, 1'b1, 8'h13});
    wait_drain(50, 1'b0);
    chk("t5_count", 32'(q.size()), 32'd4);
    errs = 0;
    for (int k = 0; k < q.size(); k++) begin
      expw = {(k == 3), 8'(8'h13 - k)};
      if (q[k] !== expw) errs++;
    end
    chk("t5_frame_intact", 32'(errs), 32'd0);

    // Asynchronous reset in the middle of a stalled drain
    cyc();
    q.delete();
    m_tready = 1'b0;
    push(8'h05, 1'b0);
    push(8'h06, 1'b0);
    push(8'h07, 1'b1);
    cyc();
    cyc();
    cyc();
    chk("t6_pre_tvalid", 32'(m_tvalid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_async_tvalid", 32'(m_tvalid), 32'd0);
    chk("t6_async_busy", 32'(busy), 32'd0);
    chk("t6_async_errdrop", 32'(err_drop), 32'd0);
    cyc();
    rst = 1'b0;
    q.delete();
    m_tready = 1'b1;
    push(8'h01, 1'b0);
    push(8'h02, 1'b1);
    chk("t6_flen", 32'(frame_len), 32'd2);
    wait_drain(20, 1'b0);
    chk("t6_count", 32'(q.size()), 32'd2);
    if (q.size() == 2) begin
      chk("t6_byte0", 32'(q[0]), 32'h002);
      chk("t6_byte1", 32'(q[1]), 32'h101);
    end

    // Overflow: fill the LIFO completely, then one extra byte with finish
    cyc();
    q.delete();
    for (int i = 0; i < DEPTH; i++) push(8'(i * 7 + 3), 1'b0);
    chk("t4_no_ovf_yet", 32'(err_ovf), 32'd0);
    push(8'hEE, 1'b1);
    chk("t4_err_ovf", 32'(err_ovf), 32'd1);
    chk("t4_flv", 32'(frame_len_valid), 32'd1);
    chk("t4_flen", 32'(frame_len), 32'(DEPTH));
    wait_drain(DEPTH + 200, 1'b0);
    chk("t4_count", 32'(q.size()), 32'(DEPTH));
    if (q.size() == DEPTH) begin
      chk("t4_first", 32'(q[0]), {23'd0, 1'b0, 8'((DEPTH - 1) * 7 + 3)});
      chk("t4_last", 32'(q[DEPTH-1]), {23'd0, 1'b1, 8'd3});
    end

    chk("axi_stability", 32'(stab_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
